// File: rtl/mips_multicycle_control_if.sv
// Memory handshake bundle between the multi-cycle control unit and the
// unified instruction/data memory.
//   mem_read  : read request (instruction fetch or lw data)
//   mem_write : write request (sw data)
//   i_or_d    : address select, 0 = PC, 1 = ALUOut
//   mem_ready : memory completes the current access this cycle
// master = control unit, slave = memory.
interface mips_multicycle_control_if;
  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_read, output mem_write, output i_or_d, input mem_ready);
  modport slave  (input mem_read, input mem_write, input i_or_d, output mem_ready);
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control unit. It sequences fetch / decode / execute /
// memory / writeback over several clocks so that one ALU and one unified
// memory are shared. It has a memory ready handshake with a watchdog,
// illegal-opcode trapping and a retire strobe.
//
// Ports:
//   clk, reset (async, active-low)
//   op, funct      : instruction fields from the IR
//   zero           : ALU zero flag (used by the datapath PC-enable gating)
//   mem            : memory handshake interface (master modport)
//   pc_write, pc_write_cond_eq/ne, pc_source : PC update control
//   ir_write, reg_write, reg_dst, mem_to_reg  : register loads / write-back
//   alu_src_a, alu_src_b, alu_op              : ALU operand and op select
//   state          : current FSM state (debug)
//   instr_retired  : one-cycle pulse on the last cycle of each instruction
//   illegal_op, bus_error : trap indicators (terminal states)
//   cycle_count, retire_count : performance counters
//
// Optional build macro MIPS_MC_PERF_COUNTERS_EN: when defined, the
// saturating performance counters are built; otherwise both ports are 0.
module mips_multicycle_control #(
  parameter int ALUOP_W        = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [5:0]               op,
  input  logic [5:0]               funct,
  input  logic                     zero,
  mips_multicycle_control_if.master mem,
  output logic                     pc_write,
  output logic                     pc_write_cond_eq,
  output logic                     pc_write_cond_ne,
  output logic [1:0]               pc_source,
  output logic                     ir_write,
  output logic                     reg_write,
  output logic [1:0]               reg_dst,
  output logic [1:0]               mem_to_reg,
  output logic                     alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic [ALUOP_W-1:0]       alu_op,
  output logic [3:0]               state,
  output logic                     instr_retired,
  output logic                     illegal_op,
  output logic                     bus_error,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         retire_count
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
    S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7,
    S_BRANCH = 4'd8, S_JUMP = 4'd9, S_JAL = 4'd10, S_JR = 4'd11,
    S_I_EXEC = 4'd12, S_I_WB = 4'd13, S_ILLEGAL = 4'd14, S_BUS_ERR = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW  = 6'b100011, OP_SW   = 6'b101011,
                         OP_ADDI  = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                         OP_LUI   = 6'b001111, OP_BEQ  = 6'b000100, OP_BNE = 6'b000101,
                         OP_J     = 6'b000010, OP_JAL  = 6'b000011, FN_JR  = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0), ALU_SUB = ALUOP_W'(1),
                                 ALU_OR  = ALUOP_W'(2), ALU_AND = ALUOP_W'(3),
                                 ALU_LUI = ALUOP_W'(4), ALU_RTYPE = ALUOP_W'(7);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Registered per-state controls. fetch/store mark the two states whose
  // strobes must additionally be qualified by mem_ready.
  typedef struct packed {
    logic               pc_write;
    logic               cond_eq;
    logic               cond_ne;
    logic [1:0]         pc_source;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               fetch;
    logic               store;
    logic               retire;
    logic               illegal;
    logic               bus_err;
  } ctrl_t;

  function automatic ctrl_t decode(input state_t s, input logic [5:0] opc);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'd1; c.fetch = 1'b1; end
      S_DECODE:   c.alu_src_b = 2'd3;
      S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
      S_MEM_RD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 2'd1; c.retire = 1'b1; end
      S_MEM_WR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; c.store = 1'b1; end
      S_R_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = ALU_RTYPE; end
      S_R_WB:     begin c.reg_write = 1'b1; c.reg_dst = 2'd1; c.retire = 1'b1; end
      S_I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        case (opc)
          OP_ANDI: c.alu_op = ALU_AND;
          OP_ORI:  c.alu_op = ALU_OR;
          OP_LUI:  c.alu_op = ALU_LUI;
          default: c.alu_op = ALU_ADD;
        endcase
      end
      S_I_WB:     begin c.reg_write = 1'b1; c.retire = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_source = 2'd1;
        c.cond_eq   = (opc == OP_BEQ);
        c.cond_ne   = (opc == OP_BNE);
        c.retire    = 1'b1;
      end
      S_JUMP:     begin c.pc_write = 1'b1; c.pc_source = 2'd2; c.retire = 1'b1; end
      S_JAL: begin
        c.pc_write   = 1'b1;
        c.pc_source  = 2'd2;
        c.reg_write  = 1'b1;
        c.reg_dst    = 2'd2;
        c.mem_to_reg = 2'd2;
        c.retire     = 1'b1;
      end
      S_JR:       begin c.pc_write = 1'b1; c.pc_source = 2'd3; c.retire = 1'b1; end
      S_ILLEGAL:  c.illegal = 1'b1;
      S_BUS_ERR:  c.bus_err = 1'b1;
      default:    ;
    endcase
    return c;
  endfunction

  state_t          state_q, state_d;
  ctrl_t           ctrl_q;
  logic [WD_W-1:0] wd_cnt;
  logic            wait_state, wd_expire;

  // The PC-enable gating with zero lives in the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign wd_expire  = (TIMEOUT_CYCLES != 0) && wait_state && !mem.mem_ready &&
                      (int'(wd_cnt) == TIMEOUT_CYCLES - 1);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem.mem_ready) state_d = S_DECODE;
                  else if (wd_expire) state_d = S_BUS_ERR;
      S_DECODE: begin
        case (op)
          OP_RTYPE:                         state_d = (funct == FN_JR) ? S_JR : S_R_EXEC;
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_I_EXEC;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_J:                             state_d = S_JUMP;
          OP_JAL:                           state_d = S_JAL;
          default:                          state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem.mem_ready) state_d = S_MEM_WB;
                  else if (wd_expire) state_d = S_BUS_ERR;
      S_MEM_WR:   if (mem.mem_ready) state_d = S_FETCH;
                  else if (wd_expire) state_d = S_BUS_ERR;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      default:    state_d = state_q;
    endcase
  end

  // Controls are registered from the next state so they line up with the
  // state register without a decode stage after the flops.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode(S_FETCH, 6'd0);
      wd_cnt  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d, op);
      if (state_d != state_q)
        wd_cnt <= '0;
      else if ((TIMEOUT_CYCLES != 0) && wait_state && !mem.mem_ready)
        wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  // mem_ready-qualified strobes are also gated by reset so nothing pulses
  // while reset is held, even though FETCH is the reset state.
  logic fetch_done, store_done;
  assign fetch_done = ctrl_q.fetch & mem.mem_ready & reset;
  assign store_done = ctrl_q.store & mem.mem_ready & reset;

  assign mem.mem_read      = ctrl_q.mem_read;
  assign mem.mem_write     = ctrl_q.mem_write;
  assign mem.i_or_d        = ctrl_q.i_or_d;
  assign pc_write          = ctrl_q.pc_write | fetch_done;
  assign ir_write          = fetch_done;
  assign pc_write_cond_eq  = ctrl_q.cond_eq;
  assign pc_write_cond_ne  = ctrl_q.cond_ne;
  assign pc_source         = ctrl_q.pc_source;
  assign reg_write         = ctrl_q.reg_write;
  assign reg_dst           = ctrl_q.reg_dst;
  assign mem_to_reg        = ctrl_q.mem_to_reg;
  assign alu_src_a         = ctrl_q.alu_src_a;
  assign alu_src_b         = ctrl_q.alu_src_b;
  assign alu_op            = ctrl_q.alu_op;
  assign state             = state_q;
  assign instr_retired     = ctrl_q.retire | store_done;
  assign illegal_op        = ctrl_q.illegal;
  assign bus_error         = ctrl_q.bus_err;

`ifdef MIPS_MC_PERF_COUNTERS_EN
  logic [CNT_W-1:0] cycle_q, retire_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      if (cycle_q != '1) cycle_q <= cycle_q + CNT_W'(1);
      if (instr_retired && (retire_q != '1)) retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
`else
  assign cycle_count  = '0;
  assign retire_count = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control with default parameters
// (TIMEOUT_CYCLES = 16). Inputs change 1 ns after the rising edge; outputs
// are compared after that settle delay.
module tb_mips_multicycle_control;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, funct;
  logic        zero;
  logic        pc_write, pc_write_cond_eq, pc_write_cond_ne, ir_write, reg_write;
  logic [1:0]  pc_source, reg_dst, mem_to_reg, alu_src_b;
  logic        alu_src_a, instr_retired, illegal_op, bus_error;
  logic [3:0]  alu_op, state;
  logic [31:0] cycle_count, retire_count;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  mips_multicycle_control_if mem_bus();

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem(mem_bus),
    .pc_write(pc_write), .pc_write_cond_eq(pc_write_cond_eq),
    .pc_write_cond_ne(pc_write_cond_ne), .pc_source(pc_source), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
    .instr_retired(instr_retired), .illegal_op(illegal_op), .bus_error(bus_error),
    .cycle_count(cycle_count), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] perf(input int v);
`ifdef MIPS_MC_PERF_COUNTERS_EN
    return 32'(v);
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Present an instruction during FETCH (mem_ready high) and step into DECODE.
  task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f, input string tag);
    op = o;
    funct = f;
    mem_bus.mem_ready = 1'b1;
    #1;
    check({tag, "_fetch_state"}, 32'(state), 32'd0);
    check({tag, "_ir_write"}, 32'(ir_write), 32'd1);
    tick();
    check({tag, "_decode_state"}, 32'(state), 32'd1);
    check({tag, "_decode_srcb"}, 32'(alu_src_b), 32'd3);
  endtask

  initial begin
    reset = 1'b0;
    op = 6'b000000;
    funct = 6'b100000;
    zero = 1'b0;
    mem_bus.mem_ready = 1'b1;

    // Reset: FETCH, strobes quiet even with mem_ready high.
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc_write", 32'(pc_write), 32'd0);
    check("rst_ir_write", 32'(ir_write), 32'd0);
    check("rst_retired", 32'(instr_retired), 32'd0);
    check("rst_cycles", cycle_count, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    edges = 0;
    #1;
    check("fetch_pc_write", 32'(pc_write), 32'd1);
    check("fetch_mem_read", 32'(mem_bus.mem_read), 32'd1);
    check("fetch_srcb", 32'(alu_src_b), 32'd1);
    check("fetch_i_or_d", 32'(mem_bus.i_or_d), 32'd0);

    // add $t0,$t1,$t2: 0,1,6,7,0
    fetch_decode(6'b000000, 6'b100000, "add");
    tick();
    check("add_rexec_state", 32'(state), 32'd6);
    check("add_rexec_aluop", 32'(alu_op), 32'd7);
    check("add_rexec_srca", 32'(alu_src_a), 32'd1);
    check("add_rexec_retired", 32'(instr_retired), 32'd0);
    tick();
    check("add_rwb_state", 32'(state), 32'd7);
    check("add_rwb_reg_write", 32'(reg_write), 32'd1);
    check("add_rwb_reg_dst", 32'(reg_dst), 32'd1);
    check("add_rwb_retired", 32'(instr_retired), 32'd1);
    tick();
    check("add_done_state", 32'(state), 32'd0);
    check("add_done_retired", 32'(instr_retired), 32'd0);
    check("add_cycles", cycle_count, perf(4));

    // lw with 3 wait cycles in MEM_RD
    fetch_decode(6'b100011, 6'b000000, "lw");
    tick();
    check("lw_addr_state", 32'(state), 32'd2);
    check("lw_addr_srcb", 32'(alu_src_b), 32'd2);
    mem_bus.mem_ready = 1'b0;
    tick();
    check("lw_rd_state", 32'(state), 32'd3);
    check("lw_rd_i_or_d", 32'(mem_bus.i_or_d), 32'd1);
    check("lw_rd_mem_read", 32'(mem_bus.mem_read), 32'd1);
    repeat (2) tick();
    check("lw_rd_hold3", 32'(state), 32'd3);
    tick();
    mem_bus.mem_ready = 1'b1;
    #1;
    check("lw_rd_hold4", 32'(state), 32'd3);
    tick();
    check("lw_wb_state", 32'(state), 32'd4);
    check("lw_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
    check("lw_wb_reg_write", 32'(reg_write), 32'd1);
    check("lw_wb_retired", 32'(instr_retired), 32'd1);
    check("lw_wb_bus_error", 32'(bus_error), 32'd0);
    tick();
    check("lw_done_state", 32'(state), 32'd0);
    check("retire_count_2", retire_count, perf(2));

    // sw: ready arrives on the 16th wait cycle, the last one allowed
    fetch_decode(6'b101011, 6'b000000, "sw");
    tick();
    mem_bus.mem_ready = 1'b0;
    tick();
    check("sw_wr_state", 32'(state), 32'd5);
    check("sw_wr_mem_write", 32'(mem_bus.mem_write), 32'd1);
    check("sw_wr_retired_wait", 32'(instr_retired), 32'd0);
    repeat (14) tick();
    check("sw_wr_hold15", 32'(state), 32'd5);
    tick();
    mem_bus.mem_ready = 1'b1;
    #1;
    check("sw_wr_last_state", 32'(state), 32'd5);
    check("sw_wr_retired", 32'(instr_retired), 32'd1);
    tick();
    check("sw_done_state", 32'(state), 32'd0);
    check("sw_done_bus_error", 32'(bus_error), 32'd0);

    // beq (zero=1 then zero=0) and bne
    for (int i = 0; i < 3; i++) begin
      zero = (i == 0);
      fetch_decode((i == 2) ? 6'b000101 : 6'b000100, 6'b000000, "br");
      tick();
      check("br_state", 32'(state), 32'd8);
      check("br_cond_eq", 32'(pc_write_cond_eq), (i == 2) ? 32'd0 : 32'd1);
      check("br_cond_ne", 32'(pc_write_cond_ne), (i == 2) ? 32'd1 : 32'd0);
      check("br_pc_source", 32'(pc_source), 32'd1);
      check("br_alu_op", 32'(alu_op), 32'd1);
      check("br_retired", 32'(instr_retired), 32'd1);
      tick();
      check("br_done_state", 32'(state), 32'd0);
    end

    // jal
    fetch_decode(6'b000011, 6'b000000, "jal");
    tick();
    check("jal_state", 32'(state), 32'd10);
    check("jal_pc_write", 32'(pc_write), 32'd1);
    check("jal_pc_source", 32'(pc_source), 32'd2);
    check("jal_reg_write", 32'(reg_write), 32'd1);
    check("jal_reg_dst", 32'(reg_dst), 32'd2);
    check("jal_mem_to_reg", 32'(mem_to_reg), 32'd2);
    tick();

    // j
    fetch_decode(6'b000010, 6'b000000, "j");
    tick();
    check("j_state", 32'(state), 32'd9);
    check("j_pc_source", 32'(pc_source), 32'd2);
    check("j_reg_write", 32'(reg_write), 32'd0);
    tick();

    // jr
    fetch_decode(6'b000000, 6'b001000, "jr");
    tick();
    check("jr_state", 32'(state), 32'd11);
    check("jr_pc_write", 32'(pc_write), 32'd1);
    check("jr_pc_source", 32'(pc_source), 32'd3);
    check("jr_retired", 32'(instr_retired), 32'd1);
    tick();

    // ori and lui
    for (int i = 0; i < 2; i++) begin
      fetch_decode((i == 0) ? 6'b001101 : 6'b001111, 6'b000000, "itype");
      tick();
      check("itype_exec_state", 32'(state), 32'd12);
      check("itype_alu_op", 32'(alu_op), (i == 0) ? 32'd2 : 32'd4);
      check("itype_srcb", 32'(alu_src_b), 32'd2);
      tick();
      check("itype_wb_state", 32'(state), 32'd13);
      check("itype_wb_reg_dst", 32'(reg_dst), 32'd0);
      check("itype_wb_reg_write", 32'(reg_write), 32'd1);
      tick();
    end

    // Illegal opcode: trapped for 20 cycles, left only by reset
    fetch_decode(6'b111111, 6'b000000, "ill");
    for (int i = 0; i < 20; i++) begin
      tick();
      check("ill_state", 32'(state), 32'd14);
      check("ill_flag", 32'(illegal_op), 32'd1);
      check("ill_quiet", {29'd0, pc_write, ir_write, mem_bus.mem_read}, 32'd0);
    end
    reset = 1'b0;
    #1;
    check("ill_rst_state", 32'(state), 32'd0);
    check("ill_rst_flag", 32'(illegal_op), 32'd0);
    check("ill_rst_strobes", {30'd0, pc_write, ir_write}, 32'd0);

    // Watchdog: FETCH with mem_ready low for 16 cycles -> BUS_ERR on cycle 17
    @(negedge clk);
    mem_bus.mem_ready = 1'b0;
    reset = 1'b1;
    edges = 0;
    repeat (15) tick();
    check("wd_cycle16_state", 32'(state), 32'd0);
    check("wd_cycle16_bus_error", 32'(bus_error), 32'd0);
    check("wd_cycles", cycle_count, perf(edges));
    tick();
    check("wd_bus_err_state", 32'(state), 32'd15);
    check("wd_bus_error", 32'(bus_error), 32'd1);
    mem_bus.mem_ready = 1'b1;
    tick();
    check("wd_terminal_state", 32'(state), 32'd15);
    check("wd_terminal_quiet", {29'd0, pc_write, ir_write, mem_bus.mem_read}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Parametrised multi-cycle control unit; successor to the single-cycle Control/ALUControl pair in MIPS_Processor.
- Moore FSM (with mem_ready-qualified strobes) sequences fetch/decode/execute/memory/writeback over several clocks, so one ALU and one unified memory are shared.
- Adds a memory ready handshake with watchdog, illegal-opcode trapping and a retire strobe.
- Sits between the instruction register (op/funct) and the multi-cycle datapath muxes and enables.

Parameters:
- ALUOP_W, 4, width of alu_op.
- TIMEOUT_CYCLES, 16, consecutive mem_ready-low cycles tolerated in a wait state; 0 disables the watchdog.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  instruction [31:26] from the IR.
- funct  in  6  instruction [5:0] from the IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond_eq  out  1  PC load if zero=1.
- pc_write_cond_ne  out  1  PC load if zero=0.
- pc_source  out  2  0 ALU result, 1 ALUOut (branch target), 2 jump address, 3 rs (jr).
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_write  out  1  register file write.
- reg_dst  out  2  0 rt, 1 rd, 2 $31.
- mem_to_reg  out  2  write-back data: 0 ALUOut, 1 MDR, 2 PC.
- alu_src_a  out  1  0 PC, 1 rs.
- alu_src_b  out  2  0 rt, 1 constant 4, 2 sign-extended immediate, 3 sign-extended immediate shifted left 2.
- alu_op  out  ALUOP_W  ALU operation code: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 LUI, 7 RTYPE (decoded downstream from funct).
- state  out  4  current state, for debug.
- instr_retired  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal_op  out  1  high while in ILLEGAL.
- bus_error  out  1  high while in BUS_ERR.
- cycle_count  out  CNT_W  performance counter, see Optional Feature.
- retire_count  out  CNT_W  performance counter, see Optional Feature.

Behaviour:
- Reset (reset=0, async): state=FETCH; watchdog counter=0; counters=0.
- All outputs default to 0 in every state except where listed below.
- State encoding: 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_RD, 4 MEM_WB, 5 MEM_WR, 6 R_EXEC, 7 R_WB, 8 BRANCH, 9 JUMP, 10 JAL, 11 JR, 12 I_EXEC, 13 I_WB, 14 ILLEGAL, 15 BUS_ERR.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0.
  - ir_write and pc_write assert only in a cycle with mem_ready=1; that cycle goes to DECODE.
  - Otherwise FETCH holds.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALUOut). Next state by op:
  - 000000 with funct 001000 -> JR; other 000000 -> R_EXEC.
  - 100011 or 101011 -> MEM_ADDR.
  - 001000, 001100, 001101 or 001111 -> I_EXEC.
  - 000100 or 000101 -> BRANCH.
  - 000010 -> JUMP; 000011 -> JAL.
  - Any other op -> ILLEGAL.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD; -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, i_or_d=1; holds until mem_ready=1, then -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; retire; -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1; holds until mem_ready=1; the mem_ready cycle retires; -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=RTYPE; -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; retire; -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2; alu_op: addi ADD, andi AND, ori OR, lui LUI; -> I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; retire; -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_source=1.
  - pc_write_cond_eq=1 for beq; pc_write_cond_ne=1 for bne.
  - Retire; -> FETCH.
- JUMP: pc_write=1, pc_source=2; retire; -> FETCH.
- JAL: pc_write=1, pc_source=2, reg_write=1, reg_dst=2, mem_to_reg=2; retire; -> FETCH.
- JR: pc_write=1, pc_source=3; retire; -> FETCH.
- ILLEGAL, BUS_ERR: terminal. No strobes asserted; exit only by reset.
- Watchdog (wait states FETCH, MEM_RD, MEM_WR):
  - Counter increments each cycle mem_ready=0 and clears on any state change.
  - If mem_ready is low for TIMEOUT_CYCLES consecutive cycles, the next state is BUS_ERR.
  - mem_ready=1 on the final allowed cycle is accepted normally.
- Latencies (states visited, FETCH with mem_ready=1 immediately):
  - R-type and I-type 4; lw 5; sw 4 + memory wait cycles.
  - beq/bne/j/jal/jr 3.
- Reset mid-instruction: immediate return to FETCH; no strobe is glitched out after reset asserts.

Optional Feature:
- Macro: MIPS_MC_PERF_COUNTERS_EN.
- Defined:
  - cycle_count increments every clock outside reset and saturates at all-ones.
  - retire_count increments on each instr_retired pulse and saturates.
- Undefined: both ports tie to 0 and no counter flops are built. instr_retired remains present in both builds.

Test Plan:
- Reset release, add $t0,$t1,$t2 (op 000000, funct 100000), mem_ready=1 -> states 0,1,6,7,0; R_WB has reg_write=1, reg_dst=1; one instr_retired pulse.
- lw, mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, mem_to_reg=1 in MEM_WB; watchdog clears; no bus_error.
- beq with zero=1 and zero=0 -> pc_write_cond_eq=1 and pc_source=1 in BRANCH both times; bne -> pc_write_cond_ne=1.
- jal -> JAL state drives pc_write=1, pc_source=2, reg_write=1, reg_dst=2, mem_to_reg=2. jr (funct 001000) -> JR drives pc_source=3.
- op 111111 -> ILLEGAL, illegal_op=1 held for 20 cycles; reset pulse -> FETCH.
- FETCH, mem_ready low 16 cycles, TIMEOUT_CYCLES=16 -> BUS_ERR on cycle 17. With macro defined: retire_count=2 after two completed instructions.
